rr_enc_arbiter: RTL

- Four-requester round-robin arbiter that shares one downstream resource and reports the winner both one-hot and as a 2-bit encoded index, matching the 4-to-2 encoder output convention.
- Sits between request sources and the shared resource.
- Holds a grant until the owner releases it or a hold-timeout expires, then rotates priority.

---
 rtl/rr_enc_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rr_enc_arbiter.sv
// Four-way round-robin arbiter with a one-hot and encoded grant.
// Grants are held until release, owner drop or a hold timeout.
module rr_enc_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam bit TO_EN = (MAX_HOLD != 0);
  localparam logic [CW-1:0] LIM =
    TO_EN ? CW'(MAX_HOLD - 1) : '0;

  state_t        r_state;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_hold;
  logic [3:0]    r_gnt;
  logic [1:0]    r_idx;
  logic          r_vld;
  logic          r_to;

  state_t        w_state_nxt;
  logic [1:0]    w_ptr_nxt;
  logic [CW-1:0] w_hold_nxt;
  logic [3:0]    w_gnt_nxt;
  logic [1:0]    w_idx_nxt;
  logic          w_vld_nxt;
  logic          w_to_nxt;

  logic [1:0]    w_win;
  logic          w_any;
  logic          w_own_req;
  logic          w_hit;
  logic          w_rel;
  logic          w_to_only;
  logic          w_sat;

  // Pick the first requester at or after the priority pointer.
  always_comb begin
    logic [1:0] v_pos;
    w_win = r_ptr;
    v_pos = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      v_pos = r_ptr + 2'(k);
      if (req[v_pos]) begin
        w_win = v_pos;
      end
    end
  end

  assign w_any     = |req;
  assign w_own_req = req[r_idx];
  assign w_sat     = &r_hold;

  // Release conditions for the current owner.
  assign w_hit     = TO_EN && (r_hold == LIM);
  assign w_rel     = done | ~w_own_req | w_hit;
  assign w_to_only = w_hit & ~done & w_own_req;

  // Next-state decision.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_rel) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    w_ptr_nxt  = r_ptr;
    w_hold_nxt = r_hold;
    w_gnt_nxt  = r_gnt;
    w_idx_nxt  = r_idx;
    w_vld_nxt  = r_vld;
    w_to_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_hold_nxt = '0;
        if (w_any) begin
          w_gnt_nxt = 4'b0001 << w_win;
          w_idx_nxt = w_win;
          w_vld_nxt = 1'b1;
        end else begin
          w_gnt_nxt = '0;
          w_idx_nxt = '0;
          w_vld_nxt = 1'b0;
        end
      end
      S_BUSY: begin
        if (w_rel) begin
          w_gnt_nxt  = '0;
          w_idx_nxt  = '0;
          w_vld_nxt  = 1'b0;
          w_ptr_nxt  = r_idx + 2'd1;
          w_hold_nxt = '0;
          w_to_nxt   = w_to_only;
        end else if (!w_sat) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: begin
        w_gnt_nxt  = '0;
        w_idx_nxt  = '0;
        w_vld_nxt  = 1'b0;
        w_hold_nxt = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_vld   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
      r_gnt   <= w_gnt_nxt;
      r_idx   <= w_idx_nxt;
      r_vld   <= w_vld_nxt;
      r_to    <= w_to_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_vld = r_vld;
  assign timeout = r_to;

endmodule
